// File: rtl/reg_wr_pkg.sv
// Shared definitions for the multi-port register-file write decoder:
// width helpers, the default port-select width and the row-select word type.
package reg_wr_pkg;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Port-select width: one bit minimum so a single-port build still has a field.
  function automatic int pselWidth(input int numPorts);
    int w;
    w = clog2(numPorts);
    return (w < 1) ? 1 : w;
  endfunction

  // Default build: 16 rows, two write ports.
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_PSEL_W    = pselWidth(DEF_NUM_PORTS);

  // Row-select word of the default build (port index driven onto one row).
  typedef logic [DEF_PSEL_W-1:0] rowSel_t;

endpackage

// File: rtl/reg_write_port_ctrl_onehot_decoder.sv
// Combinational address-to-row decoder with enable; one instance per write port.
// Its output is the per-port row request vector that arbitration works on.
module onehot_decoder
  import reg_wr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  // Exactly one row bit set when enabled, none otherwise.
  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
  end

endmodule

// File: rtl/reg_write_port_ctrl.sv
// Multi-port register-file write decoder. Each cycle it takes up to NUM_PORTS
// write requests, arbitrates same-row collisions round-robin, and drives a
// registered per-row wordline plus the winning port index for each written row.
module reg_write_port_ctrl
  import reg_wr_pkg::*;
#(
  parameter  int ADDR_W    = 4,
  parameter  int NUM_PORTS = 2,
  parameter  int ZERO_RO   = 1,
  localparam int DEPTH     = 1 << ADDR_W,
  localparam int PSEL_W    = pselWidth(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [NUM_PORTS-1:0]        wr_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
  output logic [NUM_PORTS-1:0]        wr_ready,
  output logic [DEPTH-1:0]            wordline,
  output logic [DEPTH*PSEL_W-1:0]     wl_sel,
  output logic                        conflict
);

  // Per-port row requests, already gated by valid and stall.
  logic [NUM_PORTS-1:0][DEPTH-1:0] reqRow;
  logic [NUM_PORTS-1:0]            grant;
  logic [DEPTH-1:0]                wlNext;
  logic [DEPTH*PSEL_W-1:0]         selNext;
  logic                            collAny;
  logic [PSEL_W-1:0]               rrPtr;
  logic [PSEL_W-1:0]               rrNext;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    onehot_decoder #(
      .ADDR_W (ADDR_W)
    ) uDec (
      .addr   (wr_addr[p*ADDR_W +: ADDR_W]),
      .en     (wr_valid[p] & ~stall),
      .onehot (reqRow[p])
    );
  end

  // Per-row arbitration: winner is the first requester at or after rrPtr
  // (cyclic); a read-only row 0 swallows every request without a wordline.
  always_comb begin : arbComb
    int  nReq;
    int  win;
    int  idx;
    int  lowWin;
    bit  found;
    grant   = '0;
    wlNext  = '0;
    selNext = wl_sel;
    collAny = 1'b0;
    rrNext  = rrPtr;
    lowWin  = NUM_PORTS;
    nReq    = 0;
    win     = 0;
    idx     = 0;
    found   = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      nReq = 0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (reqRow[p][r]) nReq = nReq + 1;
      end
      if ((ZERO_RO != 0) && (r == 0)) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (reqRow[p][0]) grant[p] = 1'b1;
        end
      end else if (nReq != 0) begin
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = (int'(rrPtr) + k) % NUM_PORTS;
          if (!found && reqRow[idx][r]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        grant[win]                  = 1'b1;
        wlNext[r]                   = 1'b1;
        selNext[r*PSEL_W +: PSEL_W] = PSEL_W'(win);
        if (nReq > 1) begin
          collAny = 1'b1;
          if (win < lowWin) lowWin = win;
        end
      end
    end
    if (collAny) rrNext = PSEL_W'((lowWin + 1) % NUM_PORTS);
  end

  // Ready is the grant itself, forced low while reset is held.
  assign wr_ready = rst ? '0 : grant;

  // ---- stage boundary: accepted writes become registered row strobes ----
  // Wordline/select register plus conflict flag and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordline <= '0;
      wl_sel   <= '0;
      conflict <= 1'b0;
      rrPtr    <= '0;
    end else begin
      wordline <= wlNext;
      wl_sel   <= selNext;
      if (!stall) begin
        conflict <= collAny;
        rrPtr    <= rrNext;
      end
    end
  end

endmodule
